// File: rtl/mac_accumulator_pkg.sv
// Shared constants for the MAC accumulator: lane width, cfg encodings,
// FSM state encodings and the segment carry helper.
package mac_accumulator_pkg;

  localparam int MAC_ACC_WIDTH = 16;
  localparam int MAC_MIN_WIDTH = 8;

  localparam logic [1:0] MAC_SINGLE = 2'b00;
  localparam logic [1:0] MAC_DUAL   = 2'b01;
  localparam logic [1:0] MAC_QUAD   = 2'b10;

  localparam logic [1:0] MAC_ACC_IDLE  = 2'd0;
  localparam logic [1:0] MAC_ACC_ACCUM = 2'd1;
  localparam logic [1:0] MAC_ACC_DONE  = 2'd2;

  // Per lane: carry-out of the top lane of the segment that lane belongs to.
  // Reserved cfg 2'b11 falls into the default (independent lanes).
  function automatic logic [3:0] seg_carry(input logic [1:0] cfg, input logic [3:0] cout);
    logic [3:0] r;
    r = cout;
    case (cfg)
      MAC_DUAL: r = {cout[3], cout[3], cout[1], cout[1]};
      MAC_QUAD: r = {4{cout[3]}};
      default:  r = cout;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mac_acc_lane.sv
// One W-bit accumulator lane: sum = in + acc + cin, with carry-out.
// MAC_ACC_SAT_EN adds a saturate input that forces the lane to all-ones.
module mac_acc_lane
  import mac_accumulator_pkg::*;
(
  input  logic [MAC_ACC_WIDTH-1:0] in_i,
  input  logic [MAC_ACC_WIDTH-1:0] acc_i,
  input  logic                     cin_i,
`ifdef MAC_ACC_SAT_EN
  input  logic                     sat_i,
`endif
  output logic [MAC_ACC_WIDTH-1:0] sum_o,
  output logic                     cout_o
);

  logic [MAC_ACC_WIDTH:0] raw;

  // Raw add; the carry is always the unsaturated one so the chain stays acyclic.
  always_comb begin
    raw = {1'b0, in_i} + {1'b0, acc_i} + {{MAC_ACC_WIDTH{1'b0}}, cin_i};
  end

  assign cout_o = raw[MAC_ACC_WIDTH];
`ifdef MAC_ACC_SAT_EN
  assign sum_o  = sat_i ? {MAC_ACC_WIDTH{1'b1}} : raw[MAC_ACC_WIDTH-1:0];
`else
  assign sum_o  = raw[MAC_ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Accumulator stage behind the MAC combiner: sums len beats per op with
// lanes carry-chained per cfg, then holds the result behind valid/ready.
// Optional macro MAC_ACC_SAT_EN: saturate a segment on carry-out instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; in_ready=0
// ACCUM | taking beats until count reaches its last beat
// DONE  | result valid, held until out_ready
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int LEN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_WIDTH-1:0]     len,
  input  logic [1:0]               cfg,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAC_ACC_WIDTH-1:0] in0,
  input  logic [MAC_ACC_WIDTH-1:0] in1,
  input  logic [MAC_ACC_WIDTH-1:0] in2,
  input  logic [MAC_ACC_WIDTH-1:0] in3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MAC_ACC_WIDTH-1:0] out0,
  output logic [MAC_ACC_WIDTH-1:0] out1,
  output logic [MAC_ACC_WIDTH-1:0] out2,
  output logic [MAC_ACC_WIDTH-1:0] out3,
  output logic                     overflow,
  output logic                     busy
);

  localparam int W = MAC_ACC_WIDTH;

  logic [1:0]           state_q, state_d;
  logic [1:0]           cfg_q;
  logic [LEN_WIDTH-1:0] count_q;
  logic [4*W-1:0]       acc_q, out_q, sum;
  logic                 ovf_q;
  logic [W-1:0]         sum0, sum1, sum2, sum3;
  logic                 cout0, cout1, cout2, cout3;
  logic                 cin1, cin2, cin3;
  logic [3:0]           seg_c;
  logic                 take, last;
`ifdef MAC_ACC_SAT_EN
  logic [3:0]           sat_q;
  logic [3:0]           sat_lane;
`endif

  // Chain muxing: 0->1 and 2->3 join for DUAL/QUAD, 1->2 only for QUAD.
  always_comb begin
    cin1 = ((cfg_q == MAC_DUAL) || (cfg_q == MAC_QUAD)) ? cout0 : 1'b0;
    cin2 = (cfg_q == MAC_QUAD) ? cout1 : 1'b0;
    cin3 = ((cfg_q == MAC_DUAL) || (cfg_q == MAC_QUAD)) ? cout2 : 1'b0;
  end

  assign seg_c = seg_carry(cfg_q, {cout3, cout2, cout1, cout0});
`ifdef MAC_ACC_SAT_EN
  assign sat_lane = sat_q | seg_c;
`endif

  mac_acc_lane u_lane0 (.in_i(in0), .acc_i(acc_q[W-1:0]), .cin_i(1'b0),
`ifdef MAC_ACC_SAT_EN
    .sat_i(sat_lane[0]),
`endif
    .sum_o(sum0), .cout_o(cout0));
  mac_acc_lane u_lane1 (.in_i(in1), .acc_i(acc_q[2*W-1:W]), .cin_i(cin1),
`ifdef MAC_ACC_SAT_EN
    .sat_i(sat_lane[1]),
`endif
    .sum_o(sum1), .cout_o(cout1));
  mac_acc_lane u_lane2 (.in_i(in2), .acc_i(acc_q[3*W-1:2*W]), .cin_i(cin2),
`ifdef MAC_ACC_SAT_EN
    .sat_i(sat_lane[2]),
`endif
    .sum_o(sum2), .cout_o(cout2));
  mac_acc_lane u_lane3 (.in_i(in3), .acc_i(acc_q[4*W-1:3*W]), .cin_i(cin3),
`ifdef MAC_ACC_SAT_EN
    .sat_i(sat_lane[3]),
`endif
    .sum_o(sum3), .cout_o(cout3));

  assign sum  = {sum3, sum2, sum1, sum0};
  assign take = (state_q == MAC_ACC_ACCUM) && in_valid;
  assign last = (count_q == LEN_WIDTH'(1));

  // Next-state logic for the op sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAC_ACC_IDLE:  if (start) state_d = MAC_ACC_ACCUM;
      MAC_ACC_ACCUM: if (take && last) state_d = MAC_ACC_DONE;
      MAC_ACC_DONE:  if (out_ready) state_d = MAC_ACC_IDLE;
      default:       state_d = MAC_ACC_IDLE;
    endcase
  end

  // State, op config, beat counter, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MAC_ACC_IDLE;
      cfg_q   <= MAC_SINGLE;
      count_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef MAC_ACC_SAT_EN
      sat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if ((state_q == MAC_ACC_IDLE) && start) begin
        cfg_q   <= cfg;
        count_q <= (len == '0) ? LEN_WIDTH'(1) : len;
        acc_q   <= '0;
        ovf_q   <= 1'b0;
`ifdef MAC_ACC_SAT_EN
        sat_q   <= '0;
`endif
      end else if (take) begin
        acc_q   <= sum;
        ovf_q   <= ovf_q | (|seg_c);
        count_q <= count_q - LEN_WIDTH'(1);
`ifdef MAC_ACC_SAT_EN
        sat_q   <= sat_q | seg_c;
`endif
        if (last) out_q <= sum;
      end
    end
  end

  assign in_ready  = (state_q == MAC_ACC_ACCUM);
  assign out_valid = (state_q == MAC_ACC_DONE);
  assign busy      = (state_q != MAC_ACC_IDLE);
  assign overflow  = ovf_q;
  assign out0      = out_q[W-1:0];
  assign out1      = out_q[2*W-1:W];
  assign out2      = out_q[3*W-1:2*W];
  assign out3      = out_q[4*W-1:3*W];

endmodule
